// File: rtl/mem_stream_reader_if.sv
// Bundles the command, memory-read and output-stream signals of mem_stream_reader.
// master = the reader, slave = the environment (command source, memory, stream sink).
interface mem_stream_reader_if;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [15:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    input  start, base_addr, word_count, mem_readdata, out_ready,
    output busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_clken, out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, word_count, mem_readdata, out_ready,
    input  busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_clken, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Streams word_count words from a 1-cycle-latency memory into a FWFT FIFO.
// Optional MEM_STREAM_READER_ABORT_EN adds an abort input that flushes and ends the transfer.
module mem_stream_reader #(
  parameter int MEM_WORDS  = 32896,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef MEM_STREAM_READER_ABORT_EN
  input  logic abort,
`endif
  mem_stream_reader_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [15:0]     addr;
  logic [15:0]     remaining;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic            last_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            pending, pending_last;
  logic            busy_r, done_r;
  logic            abort_req, issue, push, pop, valid;

`ifdef MEM_STREAM_READER_ABORT_EN
  assign abort_req = abort && (state == ISSUE || state == DRAIN);
`else
  assign abort_req = 1'b0;
`endif

  // Reads in flight count against FIFO space so a returning word always has a slot.
  assign issue = (state == ISSUE) && !abort_req &&
                 (int'(count) + int'(pending) < FIFO_DEPTH);
  assign push  = pending;
  assign valid = (count != '0);
  assign pop   = valid && bus.out_ready;

  assign bus.mem_address    = addr;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.out_valid      = valid;
  assign bus.out_data       = valid ? data_q[rd_ptr] : '0;
  assign bus.out_last       = valid && last_q[rd_ptr];
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      pending      <= issue;
      pending_last <= issue && (remaining == 16'd1);

      if (issue) begin
        addr      <= (addr == 16'(MEM_WORDS - 1)) ? 16'd0 : addr + 16'd1;
        remaining <= remaining - 16'd1;
      end

      if (abort_req) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        pending <= 1'b0;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= bus.mem_readdata;
          last_q[wr_ptr] <= pending_last;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      case (state)
        IDLE: if (bus.start) begin
          addr      <= bus.base_addr;
          remaining <= bus.word_count;
          busy_r    <= 1'b1;
          if (bus.word_count != 16'd0) state <= ISSUE;
          else begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (abort_req) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else if (issue && remaining == 16'd1) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_req || (pop && last_q[rd_ptr])) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: expected words/addresses queued at start,
// checked as the DUT issues reads and delivers stream words.
module tb_mem_stream_reader;
  localparam int MEM_WORDS = 32896;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
`ifdef MEM_STREAM_READER_ABORT_EN
  logic abort;
`endif
  mem_stream_reader_if b();

  mem_stream_reader #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MEM_STREAM_READER_ABORT_EN
    .abort (abort),
`endif
    .bus   (b)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk)
    if (b.mem_chipselect) b.mem_readdata <= mem[b.mem_address];

  int   errors = 0, checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [15:0] addr_q[$];
  int   done_cnt = 0, done_cyc = 0, done_base = 0;
  int   cs_cnt = 0, pop_cnt = 0, first_pop_cyc = 0, last_pop_cyc = 0, start_cyc = 0;
  int   issued = 0, popped = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: address/occupancy check on each read, data/last check on each pop.
  always @(negedge clk) begin
    if (!reset) begin
      if (b.mem_chipselect) begin
        chk("occupancy_ok", 32'(issued - popped < 4), 32'd1);
        if (addr_q.size() == 0) chk("unexpected_read", b.mem_address, 32'hFFFF_FFFF);
        else chk("mem_address", b.mem_address, addr_q.pop_front());
        issued++;
        cs_cnt++;
      end
      if (b.out_valid && b.out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", b.out_data, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", b.out_data, e.data);
          chk("out_last", b.out_last, 32'(e.last));
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
        popped++;
      end
      if (b.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [15:0] base, input logic [15:0] cnt);
    b.start      = 1'b1;
    b.base_addr  = base;
    b.word_count = cnt;
    start_cyc    = cyc;
    done_base    = done_cnt;
    pop_cnt      = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_t e;
      logic [15:0] a;
      a = 16'((int'(base) + i) % MEM_WORDS);
      addr_q.push_back(a);
      e.data = mem[a];
      e.last = (i == int'(cnt) - 1);
      exp_q.push_back(e);
    end
    tick();
    b.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    int n = 0;
    while (done_cnt == done_base && n < bound) begin
      if (rnd) b.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    b.out_ready = 1'b1;
    chk("done_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    popped = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_done"}, b.done, 0);
    chk({tag, "_valid"}, b.out_valid, 0);
    chk({tag, "_last"}, b.out_last, 0);
    chk({tag, "_cs"}, b.mem_chipselect, 0);
    chk({tag, "_addr"}, b.mem_address, 0);
    chk({tag, "_data"}, b.out_data, 0);
  endtask

  initial begin
    int snap;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i);
    reset = 1'b1;
`ifdef MEM_STREAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    b.start = 1'b0; b.base_addr = '0; b.word_count = '0; b.out_ready = 1'b1;
    b.mem_readdata = '0;
    repeat (3) tick();
    check_idle_outputs("rst");
    chk("mem_write", b.mem_write, 0);
    chk("mem_byteenable", b.mem_byteenable, 32'hF);
    chk("mem_clken", b.mem_clken, 1);
    reset = 1'b0;
    tick();

    // 8 words from 0x10 at full rate; a start while busy must be ignored
    start_xfer(16'h0010, 16'd8);
    chk("busy_on_start", b.busy, 1);
    b.start = 1'b1; b.base_addr = 16'h0200; b.word_count = 16'd3;
    tick();
    b.start = 1'b0;
    wait_done(50, 1'b0);
    chk("first_latency", 32'(first_pop_cyc - start_cyc), 32'd3);
    chk("burst_span", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
    chk("done_after_last", 32'(done_cyc - last_pop_cyc), 32'd1);
    chk("done_pulses", 32'(done_cnt - done_base), 32'd1);
    chk("busy_after_done", b.busy, 0);
    chk("queue_empty_a", 32'(exp_q.size()), 0);

    // address wrap at MEM_WORDS-1
    start_xfer(16'd32894, 16'd4);
    wait_done(50, 1'b0);
    chk("wrap_count", 32'(pop_cnt), 32'd4);
    chk("queue_empty_b", 32'(exp_q.size()), 0);

    // random backpressure
    start_xfer(16'd100, 16'd16);
    wait_done(400, 1'b1);
    chk("rand_count", 32'(pop_cnt), 32'd16);
    chk("queue_empty_c", 32'(exp_q.size()), 0);

    // zero-length transfer: no reads, a single done pulse
    snap = cs_cnt;
    start_xfer(16'h0040, 16'd0);
    wait_done(10, 1'b0);
    chk("zero_done_lat", 32'(done_cyc - start_cyc inside {[1:2]}), 32'd1);
    chk("zero_no_cs", 32'(cs_cnt - snap), 0);
    repeat (3) tick();
    chk("zero_done_once", 32'(done_cnt - done_base), 32'd1);

    // reset after 3 of 10 words
    start_xfer(16'd500, 16'd10);
    for (int n = 0; n < 50 && pop_cnt < 3; n++) tick();
    chk("pre_reset_pops", 32'(pop_cnt >= 3), 32'd1);
    reset = 1'b1;
    flush_model();
    snap = done_cnt;
    tick();
    check_idle_outputs("midrst");
    reset = 1'b0;
    repeat (6) begin
      tick();
      chk("no_stale_valid", b.out_valid, 0);
    end
    chk("no_done_after_reset", 32'(done_cnt - snap), 0);
    start_xfer(16'd700, 16'd5);
    wait_done(50, 1'b0);
    chk("post_reset_count", 32'(pop_cnt), 32'd5);
    chk("queue_empty_d", 32'(exp_q.size()), 0);

`ifdef MEM_STREAM_READER_ABORT_EN
    // abort after 5 of 12 words
    start_xfer(16'd900, 16'd12);
    for (int n = 0; n < 50 && pop_cnt < 5; n++) tick();
    chk("pre_abort_pops", 32'(pop_cnt >= 5), 32'd1);
    b.out_ready = 1'b0;
    abort = 1'b1;
    flush_model();
    snap = cs_cnt;
    tick();
    abort = 1'b0;
    b.out_ready = 1'b1;
    chk("abort_valid", b.out_valid, 0);
    chk("abort_done", b.done, 1);
    chk("abort_last", b.out_last, 0);
    tick();
    chk("abort_busy", b.busy, 0);
    repeat (5) tick();
    chk("abort_no_cs", 32'(cs_cnt - snap), 0);
    chk("abort_done_once", 32'(done_cnt - done_base), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
